// File: rtl/serial_conv_pkg.sv
// Shared types and constants for the bit-serial Excess-3 / BCD converter.
//   state_e       : frame FSM states (IDLE, RUN)
//   K_SUB3/K_ADD3 : per-digit addend, applied LSB first
//   XS3_MIN/MAX, BCD_MAX : legal input code ranges for the optional code check
//   code_invalid(): true when a raw input digit is not a legal code for the mode
package serial_conv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [3:0] K_SUB3  = 4'b1101;  // -3 mod 16
  localparam logic [3:0] K_ADD3  = 4'b0011;
  localparam logic [3:0] XS3_MIN = 4'd3;
  localparam logic [3:0] XS3_MAX = 4'd12;
  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic code_invalid(input logic mode_add3, input logic [3:0] nib);
    if (mode_add3) return (nib > BCD_MAX);
    return (nib < XS3_MIN) || (nib > XS3_MAX);
  endfunction

endpackage

// File: rtl/serial_nibble_adder.sv
// One-bit serial adder with its carry flop.
//   clk, rst_n : clock, async active-low reset
//   en         : a bit is consumed this cycle
//   x, k       : data bit and constant bit
//   restart    : treat the incoming carry as 0 (first bit of a frame)
//   last       : last bit of a digit; carry-out is dropped
//   z          : sum bit (combinational)
module serial_nibble_adder
  import serial_conv_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic x,
  input  logic k,
  input  logic restart,
  input  logic last,
  output logic z
);

  logic carry_q, carry_d;
  logic cin;

  always_comb begin
    cin     = restart ? 1'b0 : carry_q;
    z       = x ^ k ^ cin;
    carry_d = carry_q;
    if (en) carry_d = last ? 1'b0 : ((x & k) | (x & cin) | (k & cin));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) carry_q <= 1'b0;
    else        carry_q <= carry_d;
  end

endmodule

// File: rtl/serial_xs3_bcd_conv.sv
// Bit-serial, LSB-first Excess-3 <-> BCD converter with parallel frame assembly.
//   Clk, Rst  : clock, async active-low reset
//   X, En, Sof: serial input bit, bit valid, start of frame (qualified by En)
//   Z, Zv     : converted bit (Mealy) and its valid
//   DigitDone, FrameDone : registered pulses after the last bit of a digit / frame
//   Dout      : assembled frame, first digit in Dout[3:0]
//   Err, FrameErr : invalid-code pulse and sticky flag, only with XS3_ERR_CHECK_EN defined
// MODE 0 subtracts 3 per digit, MODE 1 adds 3.
//
// state | meaning
// IDLE  | waiting for En && Sof
// RUN   | inside a frame, converting each accepted bit
module serial_xs3_bcd_conv
  import serial_conv_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int MODE       = 0
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    X,
  input  logic                    En,
  input  logic                    Sof,
  output logic                    Z,
  output logic                    Zv,
  output logic                    DigitDone,
  output logic                    FrameDone,
  output logic [4*NUM_DIGITS-1:0] Dout
`ifdef XS3_ERR_CHECK_EN
  ,
  output logic                    Err,
  output logic                    FrameErr
`endif
);

  localparam int DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [DW-1:0] LAST_DIG = DW'(NUM_DIGITS - 1);
  localparam logic [3:0] K_CONST = (MODE == 0) ? K_SUB3 : K_ADD3;

  state_e                  state_q, state_d;
  logic [1:0]              bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]           dig_cnt_q, dig_cnt_d;
  logic [4*NUM_DIGITS-1:0] dout_q, dout_d;
  logic                    digit_done_q, digit_done_d;
  logic                    frame_done_q, frame_done_d;

  logic          start, accept, digit_last, frame_last, z_raw;
  logic [1:0]    bit_idx;
  logic [DW-1:0] dig_idx;

  // Sof restarts the frame whatever the state, so the indices of the bit
  // being accepted come from the counters only when no Sof is present.
  always_comb begin
    start      = En && Sof;
    accept     = Rst && En && ((state_q == RUN) || Sof);
    bit_idx    = start ? 2'd0 : bit_cnt_q;
    dig_idx    = start ? '0 : dig_cnt_q;
    digit_last = (bit_idx == 2'd3);
    frame_last = digit_last && (dig_idx == LAST_DIG);
  end

  serial_nibble_adder u_adder (
    .clk     (Clk),
    .rst_n   (Rst),
    .en      (accept),
    .x       (X),
    .k       (K_CONST[bit_idx]),
    .restart (start),
    .last    (digit_last),
    .z       (z_raw)
  );

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    dig_cnt_d    = dig_cnt_q;
    dout_d       = dout_q;
    digit_done_d = 1'b0;
    frame_done_d = 1'b0;
    if (accept) begin
      for (int d = 0; d < NUM_DIGITS; d++) begin
        for (int b = 0; b < 4; b++) begin
          if ((dig_idx == DW'(d)) && (bit_idx == 2'(b))) dout_d[4*d+b] = z_raw;
        end
      end
      digit_done_d = digit_last;
      frame_done_d = frame_last;
      if (frame_last) begin
        state_d   = IDLE;
        bit_cnt_d = 2'd0;
        dig_cnt_d = '0;
      end else begin
        state_d   = RUN;
        bit_cnt_d = bit_idx + 2'd1;
        dig_cnt_d = digit_last ? dig_idx + DW'(1) : dig_idx;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q      <= IDLE;
      bit_cnt_q    <= 2'd0;
      dig_cnt_q    <= '0;
      dout_q       <= '0;
      digit_done_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      dig_cnt_q    <= dig_cnt_d;
      dout_q       <= dout_d;
      digit_done_q <= digit_done_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign Z         = accept & z_raw;
  assign Zv        = accept;
  assign DigitDone = digit_done_q;
  assign FrameDone = frame_done_q;
  assign Dout      = dout_q;

`ifdef XS3_ERR_CHECK_EN
  logic [3:0] shadow_q, shadow_d;
  logic       err_q, err_d;
  logic       frame_err_q, frame_err_d;

  // The code check looks at shadow_d so the fourth raw bit (still on X)
  // is included in the same cycle the digit completes.
  always_comb begin
    shadow_d = shadow_q;
    if (accept) shadow_d[bit_idx] = X;
    err_d       = accept && digit_last && code_invalid(MODE == 1, shadow_d);
    frame_err_d = frame_err_q;
    if (start) frame_err_d = 1'b0;
    if (err_d) frame_err_d = 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      shadow_q    <= 4'd0;
      err_q       <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      err_q       <= err_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign Err      = err_q;
  assign FrameErr = frame_err_q;
`endif

endmodule

// File: tb/tb_serial_xs3_bcd_conv.sv
module tb_serial_xs3_bcd_conv;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic X = 1'b0, En = 1'b0, Sof = 1'b0;

  always #5 Clk = ~Clk;

  logic z1, zv1, dd1, fd1;  logic [3:0]  dout1;
  logic z4, zv4, dd4, fd4;  logic [15:0] dout4;
  logic zm, zvm, ddm, fdm;  logic [7:0]  doutm;
`ifdef XS3_ERR_CHECK_EN
  logic err1, fe1, err4, fe4, errm, fem;
`endif

  serial_xs3_bcd_conv #(.NUM_DIGITS(1), .MODE(0)) u_d1 (
    .Clk(Clk), .Rst(Rst), .X(X), .En(En), .Sof(Sof), .Z(z1), .Zv(zv1),
    .DigitDone(dd1), .FrameDone(fd1), .Dout(dout1)
`ifdef XS3_ERR_CHECK_EN
    , .Err(err1), .FrameErr(fe1)
`endif
  );

  serial_xs3_bcd_conv #(.NUM_DIGITS(4), .MODE(0)) u_d4 (
    .Clk(Clk), .Rst(Rst), .X(X), .En(En), .Sof(Sof), .Z(z4), .Zv(zv4),
    .DigitDone(dd4), .FrameDone(fd4), .Dout(dout4)
`ifdef XS3_ERR_CHECK_EN
    , .Err(err4), .FrameErr(fe4)
`endif
  );

  serial_xs3_bcd_conv #(.NUM_DIGITS(2), .MODE(1)) u_m1 (
    .Clk(Clk), .Rst(Rst), .X(X), .En(En), .Sof(Sof), .Z(zm), .Zv(zvm),
    .DigitDone(ddm), .FrameDone(fdm), .Dout(doutm)
`ifdef XS3_ERR_CHECK_EN
    , .Err(errm), .FrameErr(fem)
`endif
  );

  logic        z_a[3], zv_a[3], dd_a[3], fd_a[3];
  logic [31:0] dout_a[3];
`ifdef XS3_ERR_CHECK_EN
  logic        err_a[3], fe_a[3];
`endif

  always_comb begin
    z_a[0] = z1;  zv_a[0] = zv1; dd_a[0] = dd1; fd_a[0] = fd1; dout_a[0] = 32'(dout1);
    z_a[1] = z4;  zv_a[1] = zv4; dd_a[1] = dd4; fd_a[1] = fd4; dout_a[1] = 32'(dout4);
    z_a[2] = zm;  zv_a[2] = zvm; dd_a[2] = ddm; fd_a[2] = fdm; dout_a[2] = 32'(doutm);
`ifdef XS3_ERR_CHECK_EN
    err_a[0] = err1; fe_a[0] = fe1;
    err_a[1] = err4; fe_a[1] = fe4;
    err_a[2] = errm; fe_a[2] = fem;
`endif
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    n_total++;
    if (got === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp_v, $time);
  endtask

  // Behavioural model: per instance, track position in frame and the raw digit
  // bits seen so far. Output bit b of a digit is bit b of (raw_low_bits + K) mod 16,
  // since carries only travel upwards.
  int          nd[3] = '{1, 4, 2};
  int          kk[3] = '{13, 13, 3};
  bit          md[3] = '{1'b0, 1'b0, 1'b1};
  bit          act[3];
  int          pos[3];
  int          raw[3];
  bit          dd_e[3], fd_e[3], hold[3];
  logic [31:0] frame_w[3], dout_e[3];
`ifdef XS3_ERR_CHECK_EN
  bit          err_e[3], fe_e[3];
`endif

  always @(negedge Clk) begin : cmp
    int  b, d, nib;
    bit  acc, ez;
    for (int i = 0; i < 3; i++) begin
      if (!Rst) begin
        chk("rst_z", 32'(z_a[i]), 0);
        chk("rst_zv", 32'(zv_a[i]), 0);
        chk("rst_digit_done", 32'(dd_a[i]), 0);
        chk("rst_frame_done", 32'(fd_a[i]), 0);
        chk("rst_dout", dout_a[i], 0);
        act[i] = 0; pos[i] = 0; raw[i] = 0; dd_e[i] = 0; fd_e[i] = 0;
        hold[i] = 1; frame_w[i] = '0; dout_e[i] = '0;
`ifdef XS3_ERR_CHECK_EN
        err_e[i] = 0; fe_e[i] = 0;
`endif
      end else begin
        chk("digit_done", 32'(dd_a[i]), 32'(dd_e[i]));
        chk("frame_done", 32'(fd_a[i]), 32'(fd_e[i]));
        if (hold[i]) chk("dout_hold", dout_a[i], dout_e[i]);
`ifdef XS3_ERR_CHECK_EN
        chk("err", 32'(err_a[i]), 32'(err_e[i]));
        chk("frame_err", 32'(fe_a[i]), 32'(fe_e[i]));
        err_e[i] = 0;
`endif
        acc = En && (Sof || act[i]);
        if (En && Sof) begin
          act[i] = 1; pos[i] = 0; raw[i] = 0; hold[i] = 0;
`ifdef XS3_ERR_CHECK_EN
          fe_e[i] = 0;
`endif
        end
        ez = 0; dd_e[i] = 0; fd_e[i] = 0;
        if (acc) begin
          b = pos[i] % 4;
          d = pos[i] / 4;
          raw[i] = raw[i] | (int'(X) << b);
          ez = bit'(((raw[i] + kk[i]) >> b) & 1);
          pos[i]++;
          if (b == 3) begin
            nib = (raw[i] + kk[i]) % 16;
            frame_w[i][4*d +: 4] = 4'(nib);
            dd_e[i] = 1;
`ifdef XS3_ERR_CHECK_EN
            err_e[i] = md[i] ? (raw[i] > 9) : (raw[i] < 3 || raw[i] > 12);
            if (err_e[i]) fe_e[i] = 1;
`endif
            raw[i] = 0;
          end
          if (pos[i] == 4 * nd[i]) begin
            fd_e[i] = 1; act[i] = 0; hold[i] = 1; dout_e[i] = frame_w[i];
          end
        end
        chk("z", 32'(z_a[i]), 32'(ez));
        chk("zv", 32'(zv_a[i]), 32'(acc));
        if (md[i] && !acc) chk("mode1_idle_z", 32'(z_a[i]), 0);
      end
    end
  end

  task automatic cyc(input logic x, input logic en, input logic sof);
    X = x; En = en; Sof = sof;
    @(posedge Clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_digit(input int v, input bit sof);
    for (int b = 0; b < 4; b++) cyc(1'((v >> b) & 1), 1'b1, sof && (b == 0));
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b1;
    idle(2);
    chk("lit_reset_dout4", 32'(dout4), 0);

    // XS3 3..12 on single-digit frames -> BCD 0..9
    for (int v = 3; v <= 12; v++) begin
      send_digit(v, 1'b1);
      chk("lit_t1_dout1", 32'(dout1), 32'(v - 3));
      chk("lit_t1_frame_done", 32'(fd1), 1);
      idle(1);
    end

    // XS3 4,5,6,7 -> 16'h4321
    send_digit(4, 1'b1); send_digit(5, 1'b0); send_digit(6, 1'b0); send_digit(7, 1'b0);
    chk("lit_t2_dout4", 32'(dout4), 32'h4321);
    chk("lit_t2_frame_done", 32'(fd4), 1);
    idle(2);

    // same frame with a 3-cycle gap after bit 1 of digit 2
    send_digit(4, 1'b1); send_digit(5, 1'b0);
    cyc(1'b0, 1'b1, 1'b0); cyc(1'b1, 1'b1, 1'b0);
    for (int g = 0; g < 3; g++) begin
      X = 1'b1; En = 1'b0; Sof = 1'b0;
      #2 chk("lit_t3_gap_zv", 32'(zv4), 0);
      chk("lit_t3_gap_z", 32'(z4), 0);
      @(posedge Clk); #1;
    end
    cyc(1'b1, 1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b0);
    send_digit(7, 1'b0);
    chk("lit_t3_dout4", 32'(dout4), 32'h4321);
    idle(2);

    // abort after 6 bits, then XS3 9,9,9,9 -> 16'h6666
    send_digit(9, 1'b1); cyc(1'b1, 1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b0);
    send_digit(9, 1'b1); send_digit(9, 1'b0); send_digit(9, 1'b0); send_digit(9, 1'b0);
    chk("lit_t4_dout4", 32'(dout4), 32'h6666);
    idle(2);

    // reset mid-frame, then XS3 12,3,3,3 -> 16'h0009
    send_digit(5, 1'b1); cyc(1'b1, 1'b1, 1'b0); cyc(1'b0, 1'b1, 1'b0);
    X = 1'b1; En = 1'b1; Sof = 1'b0; Rst = 1'b0;
    #1 chk("lit_t5_rst_z", 32'(z4), 0);
    chk("lit_t5_rst_zv", 32'(zv4), 0);
    chk("lit_t5_rst_dout", 32'(dout4), 0);
    @(posedge Clk); #1;
    Rst = 1'b1; En = 1'b0;
    idle(1);
    send_digit(12, 1'b1); send_digit(3, 1'b0); send_digit(3, 1'b0); send_digit(3, 1'b0);
    chk("lit_t5_dout4", 32'(dout4), 32'h0009);
    idle(2);

    // MODE 1: BCD 9 -> 12 (valid), BCD 15 -> 2 (invalid code)
    send_digit(9, 1'b1); send_digit(15, 1'b0);
    chk("lit_t6_doutm", 32'(doutm), 32'h2C);
`ifdef XS3_ERR_CHECK_EN
    chk("lit_t6_err", 32'(errm), 1);
    chk("lit_t6_frame_err", 32'(fem), 1);
`endif
    idle(2);
`ifdef XS3_ERR_CHECK_EN
    chk("lit_t6_frame_err_sticky", 32'(fem), 1);
`endif
    send_digit(9, 1'b1); send_digit(9, 1'b0);
    chk("lit_t6_doutm2", 32'(doutm), 32'hCC);
`ifdef XS3_ERR_CHECK_EN
    chk("lit_t6_frame_err_clr", 32'(fem), 0);
`endif
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
